// File: rtl/trace_buffer.sv
// Retirement trace buffer: circular store of {pc, result} with a freeze/browse mode.
// Optional drop counter built only when TRACE_DROP_CNT_EN is defined.
module trace_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire_valid,
  input  logic [WIDTH-1:0] retire_pc,
  input  logic [WIDTH-1:0] retire_result,
  input  logic             freeze,
  input  logic             older,
  input  logic             newer,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       age,
  output logic [4:0]       count,
  output logic             frozen,
  output logic [7:0]       drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] FROZEN = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [4:0]         count_q, count_d;
  logic [3:0]         age_q, age_d;
  logic [WIDTH-1:0]   pc_q, pc_d, result_q, result_d;
  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic               wr_en;
  logic [AW-1:0]      rd_idx;

  always_comb begin
    state_d  = freeze ? FROZEN : RUN;
    wr_en    = (state_q == RUN) && retire_valid;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (wr_en && count_q != 5'(DEPTH)) count_d = count_q + 5'd1;

    // Age only moves while staying frozen; any other case (RUN, or leaving FROZEN) forces it to 0.
    age_d = '0;
    if (state_q == FROZEN && freeze) begin
      age_d = age_q;
      if (count_q != 5'd0) begin
        if (older && !newer && {1'b0, age_q} < count_q - 5'd1) age_d = age_q + 4'd1;
        else if (newer && !older && age_q != 4'd0)            age_d = age_q - 4'd1;
      end
    end

    // DEPTH is a power of two, so pointer truncation gives the modulo for free.
    rd_idx = wr_ptr_q - AW'(1) - age_q[AW-1:0];
    if (count_q == 5'd0) {pc_d, result_d} = '0;
    else                 {pc_d, result_d} = mem_q[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      wr_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      pc_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
      pc_q     <= pc_d;
      result_q <= result_d;
    end
  end

  // Storage is never cleared; count gates what can be presented.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_ptr_q] <= {retire_pc, retire_result};
  end

`ifdef TRACE_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (state_q == RUN && freeze)                                 drop_d = 8'd0;
    else if (state_q == FROZEN && retire_valid && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

  assign pc     = pc_q;
  assign result = result_q;
  assign age    = age_q;
  assign count  = count_q;
  assign frozen = (state_q == FROZEN);

endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer: directed scenarios plus randomized traffic
// checked against a queue-based model of the trace history.
module tb_trace_buffer;
  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             retire_valid = 1'b0;
  logic [WIDTH-1:0] retire_pc = '0;
  logic [WIDTH-1:0] retire_result = '0;
  logic             freeze = 1'b0;
  logic             older = 1'b0;
  logic             newer = 1'b0;
  logic [WIDTH-1:0] pc, result;
  logic [3:0]       age;
  logic [4:0]       count;
  logic             frozen;
  logic [7:0]       drop_cnt;

  int checks = 0;
  int errors = 0;

  trace_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_result(retire_result), .freeze(freeze), .older(older), .newer(newer),
    .pc(pc), .result(result), .age(age), .count(count), .frozen(frozen), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: history queue (newest at back), browse offset, drop tally.
  logic [WIDTH-1:0] mq_pc[$];
  logic [WIDTH-1:0] mq_res[$];
  bit               m_frozen = 0;
  int               m_age = 0;
  int               m_drop = 0;
  logic [WIDTH-1:0] exp_pc = '0, exp_res = '0;
  logic [7:0]       exp_drop;

  task automatic cyc(input bit rs, input bit rv, input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] r,
                     input bit frz, input bit o, input bit n);
    logic [WIDTH-1:0] dp, dr;
    rst = rs; retire_valid = rv; retire_pc = p; retire_result = r;
    freeze = frz; older = o; newer = n;
    @(posedge clk);
    if (rs) begin
      mq_pc.delete(); mq_res.delete();
      m_frozen = 0; m_age = 0; m_drop = 0; exp_pc = '0; exp_res = '0;
    end else begin
      dp = '0; dr = '0;
      if (mq_pc.size() > 0) begin
        dp = mq_pc[mq_pc.size() - 1 - m_age];
        dr = mq_res[mq_res.size() - 1 - m_age];
      end
      if (!m_frozen) begin
        if (rv) begin
          mq_pc.push_back(p); mq_res.push_back(r);
          if (mq_pc.size() > DEPTH) begin
            void'(mq_pc.pop_front()); void'(mq_res.pop_front());
          end
        end
        m_age = 0;
        if (frz) begin m_frozen = 1; m_drop = 0; end
      end else begin
        if (rv && m_drop < 255) m_drop++;
        if (!frz) begin m_frozen = 0; m_age = 0; end
        else if (o && !n && m_age + 1 < mq_pc.size()) m_age++;
        else if (n && !o && m_age > 0) m_age--;
      end
      exp_pc = dp; exp_res = dr;
    end
`ifdef TRACE_DROP_CNT_EN
    exp_drop = 8'(m_drop);
`else
    exp_drop = 8'd0;
`endif
    #1;
    rst = 1'b0; retire_valid = 1'b0; older = 1'b0; newer = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1, 1, 32'hDEAD, 32'hBEEF, 0, 0, 0);
    checks++;
    if ({pc, result, age, count, frozen, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset: pc=%h result=%h age=%0d count=%0d frozen=%b drop=%0d, required all 0",
               pc, result, age, count, frozen, drop_cnt);
    end
  endtask

  task automatic test_basic_retire();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h100, 32'hA, 0, 0, 0);
    cyc(0, 1, 32'h104, 32'hB, 0, 0, 0);
    cyc(0, 1, 32'h108, 32'hC, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (count !== 5'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", count); end
    checks++;
    if (pc !== 32'h108 || result !== 32'hC) begin
      errors++; $display("FAIL basic_newest: got pc=%h result=%h want 108/c", pc, result);
    end
  endtask

  task automatic test_fill_browse();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, WIDTH'(i), WIDTH'(i + 32'h50), 0, 0, 0);
    checks++;
    if (count !== 5'd8) begin errors++; $display("FAIL fill_count: got %0d want 8", count); end
    cyc(0, 0, 0, 0, 1, 1, 0);
    checks++;
    if (frozen !== 1'b1 || age !== 4'd0) begin
      errors++; $display("FAIL fill_freeze: frozen=%b age=%0d want 1/0", frozen, age);
    end
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 1, 1, 0);
    checks++;
    if (age !== 4'd7) begin errors++; $display("FAIL fill_age7: got %0d want 7", age); end
    cyc(0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (pc !== 32'd2 || result !== 32'h52) begin
      errors++; $display("FAIL fill_oldest: got pc=%h result=%h want 2/52", pc, result);
    end
    cyc(0, 0, 0, 0, 1, 1, 0);
    checks++;
    if (age !== 4'd7) begin errors++; $display("FAIL fill_age_sat: got %0d want 7", age); end
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (age !== 4'd5 || pc !== 32'd4) begin
      errors++; $display("FAIL fill_newer: got age=%0d pc=%h want 5/4", age, pc);
    end
  endtask

  task automatic test_drop_saturation();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, WIDTH'(32'h200 + 4 * i), WIDTH'(i), 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 300; i++) cyc(0, 1, $urandom, $urandom, 1, 0, 0);
    checks++;
`ifdef TRACE_DROP_CNT_EN
    if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d want 255", drop_cnt); end
`else
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL drop_off: got %0d want 0", drop_cnt); end
`endif
    checks++;
    if (count !== 5'd5 || pc !== 32'h210 || result !== 32'd4) begin
      errors++; $display("FAIL drop_contents: count=%0d pc=%h result=%h want 5/210/4", count, pc, result);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (frozen !== 1'b0 || drop_cnt !== exp_drop || pc !== 32'h210) begin
      errors++; $display("FAIL drop_release: frozen=%b drop=%0d pc=%h want 0/%0d/210", frozen, drop_cnt, pc, exp_drop);
    end
  endtask

  task automatic test_simultaneous_keys();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, WIDTH'(4 * i), ~WIDTH'(i), 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 1, 1);
    checks++;
    if (age !== 4'd3) begin errors++; $display("FAIL keys_both: got age %0d want 3", age); end
    cyc(0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (pc !== 32'd16 || result !== ~32'd4) begin
      errors++; $display("FAIL keys_view: got pc=%h result=%h want 10/fffffffb", pc, result);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (age !== 4'd0 || frozen !== 1'b0) begin
      errors++; $display("FAIL keys_release: age=%0d frozen=%b want 0/0", age, frozen);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pc !== 32'd28 || result !== ~32'd7) begin
      errors++; $display("FAIL keys_newest: got pc=%h result=%h want 1c/fffffff8", pc, result);
    end
  endtask

  task automatic test_empty_and_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (age !== 4'd0 || pc !== '0 || result !== '0) begin
      errors++; $display("FAIL empty_browse: age=%0d pc=%h result=%h want 0/0/0", age, pc, result);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, WIDTH'(32'h300 + i), WIDTH'(i + 1), 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h999, 32'h999, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 1, 32'h777, 32'h777, 1, 1, 0);
    checks++;
    if ({pc, result, age, count, frozen, drop_cnt} !== '0) begin
      errors++; $display("FAIL midbrowse_reset: pc=%h result=%h age=%0d count=%0d frozen=%b drop=%0d, required all 0",
                         pc, result, age, count, frozen, drop_cnt);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (count !== 5'd0 || pc !== '0) begin
      errors++; $display("FAIL reset_discard: count=%0d pc=%h want 0/0", count, pc);
    end
  endtask

  task automatic test_random();
    bit frz_lvl = 0;
    int bad = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) frz_lvl = !frz_lvl;
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, $urandom, $urandom, frz_lvl,
          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      checks++;
      if (pc !== exp_pc || result !== exp_res || age !== 4'(m_age) || count !== 5'(mq_pc.size()) ||
          frozen !== m_frozen || drop_cnt !== exp_drop) begin
        errors++;
        if (bad < 10)
          $display("FAIL random[%0d]: got pc=%h res=%h age=%0d cnt=%0d frz=%b drop=%0d want pc=%h res=%h age=%0d cnt=%0d frz=%b drop=%0d",
                   i, pc, result, age, count, frozen, drop_cnt, exp_pc, exp_res, m_age, mq_pc.size(), m_frozen, exp_drop);
        bad++;
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_retire();
    test_fill_browse();
    test_drop_saturation();
    test_simultaneous_keys();
    test_empty_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of stored trace entries; a power of two in 2..16.
REQ-002 SHALL have parameter WIDTH, default 32, meaning width of the pc and result fields.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port retire_valid, input, 1, one-cycle strobe: an instruction retired this cycle.
REQ-006 SHALL have port retire_pc, input, WIDTH, pc of the retiring instruction.
REQ-007 SHALL have port retire_result, input, WIDTH, writeback value of the retiring instruction.
REQ-008 SHALL have port freeze, input, 1, level signal (from a slide switch) selecting browse mode.
REQ-009 SHALL have port older, input, 1, one-cycle debounced key pulse: step the view one entry back.
REQ-010 SHALL have port newer, input, 1, one-cycle debounced key pulse: step the view one entry forward.
REQ-011 SHALL have port pc, output, WIDTH, registered pc of the viewed entry (feeds the display stage).
REQ-012 SHALL have port result, output, WIDTH, registered result of the viewed entry (feeds the display stage).
REQ-013 SHALL have port age, output, 4, offset of the viewed entry from the newest entry (0 = newest).
REQ-014 SHALL have port count, output, 5, number of valid entries, 0..DEPTH.
REQ-015 SHALL have port frozen, output, 1, high while in state FROZEN.
REQ-016 SHALL have port drop_cnt, output, 8, number of retirements dropped while frozen.

Function
REQ-017 SHALL store entries in a circular buffer; wr_ptr advances modulo DEPTH on each accepted write.
REQ-018 SHALL have a two-state FSM, RUN and FROZEN; RUN->FROZEN when freeze=1, FROZEN->RUN when freeze=0; each transition takes effect on the next edge.
REQ-019 In RUN, SHALL accept every retire_valid: write {retire_pc, retire_result} at wr_ptr and increment count, saturating at DEPTH; once full, the oldest entry is overwritten.
REQ-020 In RUN, SHALL hold age at 0 and ignore older/newer.
REQ-021 In RUN, pc/result SHALL show the newest entry with one cycle latency: a write at edge N is visible after edge N+1.
REQ-022 In FROZEN, SHALL not write the buffer; each retire_valid SHALL instead increment drop_cnt, which saturates at 255.
REQ-023 In FROZEN, older SHALL increment age if age < count-1, otherwise hold; newer SHALL decrement age if age > 0, otherwise hold; there is no wrap-around.
REQ-024 If older and newer are asserted in the same cycle, age SHALL not change.
REQ-025 In FROZEN, pc/result SHALL show entry (wr_ptr-1-age) mod DEPTH, updating one cycle after age changes.
REQ-026 On FROZEN->RUN, age SHALL clear to 0; drop_cnt SHALL hold until the next RUN->FROZEN transition, where it clears to 0.
REQ-027 If count=0, pc and result SHALL read 0 in either state, and older/newer SHALL have no effect.
REQ-028 A retire_valid in the same cycle as RUN->FROZEN SHALL be accepted, because the state is still RUN on that edge.

Reset
REQ-029 On rst=1 at a clock edge: state=RUN, wr_ptr=0, count=0, age=0, pc=0, result=0, frozen=0, drop_cnt=0.
REQ-030 Buffer contents need not be cleared; entries at or above count SHALL never be presented.
REQ-031 rst SHALL take priority over all other inputs, including mid-browse and mid-write; retire_valid in the reset cycle SHALL be discarded.

Configuration
REQ-032 With macro TRACE_DROP_CNT_EN defined, drop counting SHALL be implemented per REQ-022 and REQ-026.
REQ-033 Without TRACE_DROP_CNT_EN, drop_cnt SHALL be tied to 0 and no counter logic SHALL be built; FROZEN still drops writes.

Verification
REQ-034 Reset, then 3 retires with pc=0x100/0x104/0x108 and result=0xA/0xB/0xC -> count=3; pc=0x108, result=0xC one cycle after the last write.
REQ-035 DEPTH=8, 10 retires with pc=0..9 -> count=8; freeze, then press older 7 times -> age=7, pc=2; an 8th older press -> age stays 7.
REQ-036 Frozen, 300 retire strobes -> drop_cnt=255 (with the macro) or 0 (without); buffer contents unchanged.
REQ-037 Frozen at age=3, older and newer pulsed in the same cycle -> age=3; release freeze -> age=0 and pc shows the newest entry.
REQ-038 Empty buffer, freeze and press older -> age=0, pc=0, result=0; rst asserted mid-browse -> all outputs reach reset values on the next edge.
